// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns HI/LO and borrows the shared EX-stage ALU
// while running: shift-add multiply, restoring divide, with a final sign fix-up cycle.
module muldiv_seq #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0101
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  input  logic [3:0]       ex_controls,
  input  logic [WIDTH-1:0] ex_a,
  input  logic [WIDTH-1:0] ex_b,
  output logic [3:0]       alu_controls,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0]   ONE  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE2 = (2*WIDTH)'(1);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

  state_t           state;
  logic             is_div;
  logic             sign_a;
  logic             sign_b;
  logic             div_zero;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] orig_a;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CW-1:0]    iter;

  logic             a_neg_in;
  logic             b_neg_in;
  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH-1:0] b_mag_in;
  logic [WIDTH-1:0] div_r;
  logic             mul_cout;
  logic             div_borrow;
  logic             div_take;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand magnitudes are only taken for the signed ops (op[0]=1).
  always_comb begin
    a_neg_in = op[0] & a[WIDTH-1];
    b_neg_in = op[0] & b[WIDTH-1];
    a_mag_in = a_neg_in ? (~a + ONE) : a;
    b_mag_in = b_neg_in ? (~b + ONE) : b;
  end

  // Input mux in front of the shared ALU; the sequencer owns it only in RUN.
  always_comb begin
    div_r        = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
    alu_controls = ex_controls;
    alu_a        = ex_a;
    alu_b        = ex_b;
    if (state == S_RUN) begin
      if (is_div) begin
        alu_controls = ALU_SUB;
        alu_a        = div_r;
        alu_b        = mag_b;
      end else begin
        alu_controls = ALU_ADD;
        alu_a        = acc_hi;
        alu_b        = mag_a;
      end
    end
  end

  // Carry and borrow recovered from operand and result sign bits, since the ALU exports neither.
  always_comb begin
    mul_cout   = (alu_a[WIDTH-1] & alu_b[WIDTH-1]) |
                 ((alu_a[WIDTH-1] | alu_b[WIDTH-1]) & ~alu_out[WIDTH-1]);
    div_borrow = (~alu_a[WIDTH-1] & alu_b[WIDTH-1]) |
                 ((~alu_a[WIDTH-1] | alu_b[WIDTH-1]) & alu_out[WIDTH-1]);
    div_take   = acc_hi[WIDTH-1] | ~div_borrow;
  end

  always_comb begin
    prod_raw = {acc_hi, acc_lo};
    prod_fix = (sign_a ^ sign_b) ? (~prod_raw + ONE2) : prod_raw;
    quo_fix  = (sign_a ^ sign_b) ? (~acc_lo + ONE) : acc_lo;
    rem_fix  = sign_a ? (~acc_hi + ONE) : acc_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      orig_a   <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      iter     <= '0;
    end else begin
      done <= 1'b0;
      if (flush && (state != S_IDLE)) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              is_div   <= op[1];
              sign_a   <= a_neg_in;
              sign_b   <= b_neg_in;
              mag_a    <= a_mag_in;
              mag_b    <= b_mag_in;
              orig_a   <= a;
              div_zero <= op[1] & (b == '0);
              busy     <= 1'b1;
              state    <= S_PREP;
            end
          end
          S_PREP: begin
            iter   <= '0;
            acc_hi <= '0;
            acc_lo <= is_div ? mag_a : mag_b;
            state  <= S_RUN;
          end
          S_RUN: begin
            if (is_div) begin
              acc_hi <= div_take ? alu_out : div_r;
              acc_lo <= {acc_lo[WIDTH-2:0], div_take};
            end else if (acc_lo[0]) begin
              {acc_hi, acc_lo} <= {mul_cout, alu_out, acc_lo[WIDTH-1:1]};
            end else begin
              {acc_hi, acc_lo} <= {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
            end
            iter <= iter + CW'(1);
            if (iter == CW'(WIDTH - 1)) begin
              state <= S_FIX;
            end
          end
          S_FIX: begin
            if (!is_div) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (div_zero) begin
              hi <= orig_a;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random operations compared
// against a plain-arithmetic reference model; the bench also plays the role of the shared ALU.
module tb_muldiv_seq;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [3:0]  ex_controls = '0;
  logic [31:0] ex_a = '0;
  logic [31:0] ex_b = '0;
  logic [3:0]  alu_controls;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .ex_controls(ex_controls), .ex_a(ex_a), .ex_b(ex_b),
    .alu_controls(alu_controls), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
  );

  // Stand-in for the shared EX-stage ALU.
  always_comb begin
    alu_out = alu_a ^ alu_b;
    case (alu_controls)
      ALU_ADD: alu_out = alu_a + alu_b;
      ALU_SUB: alu_out = alu_a - alu_b;
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      default: alu_out = alu_a ^ alu_b;
    endcase
  end

  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    res = '0;
    case (o)
      2'b00: res = {32'b0, x} * {32'b0, y};
      2'b01: res = 64'(sx * sy);
      2'b10: res = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: begin
        if (y == 0) begin
          res = {x, 32'hFFFF_FFFF};
        end else begin
          q   = sx / sy;
          r   = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  function automatic logic [31:0] mag(input logic sgn, input logic [31:0] x);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives a request at the current negedge and follows it until done, flush-abort or timeout.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input int glitch_at, input int flush_at, input bit flush_with_start,
                               output int busy_cycles, output bit saw_done,
                               output logic [3:0] ctl_mid, output logic [31:0] b_mid);
    busy_cycles = 0;
    saw_done    = 1'b0;
    ctl_mid     = '0;
    b_mid       = '0;
    ex_controls = 4'hF;
    ex_a        = $urandom;
    ex_b        = $urandom;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    flush = flush_with_start;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        saw_done = 1'b1;
        break;
      end
      if (!busy) break;
      busy_cycles++;
      if (busy_cycles == 5) begin
        ctl_mid = alu_controls;
        b_mid   = alu_b;
      end
      start = (busy_cycles == glitch_at);
      flush = (busy_cycles == flush_at);
      @(negedge clk);
    end
    start = 1'b0;
    flush = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input logic [1:0] o, input logic [31:0] x,
                             input logic [31:0] y, input int glitch_at, input bit flush_with_start);
    int          bc;
    bit          sd;
    logic [3:0]  ctl_mid;
    logic [31:0] b_mid;
    logic [63:0] expv;
    expv = ref_model(o, x, y);
    applyStimulus(o, x, y, glitch_at, -1, flush_with_start, bc, sd, ctl_mid, b_mid);
    checkOutput({tag, "_done"}, 64'(sd), 64'd1);
    checkOutput({tag, "_busy_cycles"}, 64'(bc), 64'd34);
    checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    checkOutput({tag, "_hi"}, 64'(hi), 64'(expv[63:32]));
    checkOutput({tag, "_lo"}, 64'(lo), 64'(expv[31:0]));
    checkOutput({tag, "_alu_ctl_run"}, 64'(ctl_mid), 64'(o[1] ? ALU_SUB : ALU_ADD));
    checkOutput({tag, "_alu_b_run"}, 64'(b_mid), 64'(o[1] ? mag(o[0], y) : mag(o[0], x)));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          bc;
    bit          sd;
    int          done_count;
    logic [3:0]  ctl_mid;
    logic [31:0] b_mid;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    ex_controls = 4'b0010;
    ex_a = 32'd3;
    ex_b = 32'd4;
    #12;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_hi", 64'(hi), 64'd0);
    checkOutput("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_alu_ctl", 64'(alu_controls), 64'h2);
    checkOutput("idle_alu_a", 64'(alu_a), 64'd3);
    checkOutput("idle_alu_b", 64'(alu_b), 64'd4);
    checkOutput("idle_alu_out", 64'(alu_out), 64'd7);

    runAndCheck("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    checkOutput("multu_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
    checkOutput("multu_max_lo_const", 64'(lo), 64'h0000_0001);
    runAndCheck("mult_neg_flushidle", 2'b01, 32'hFFFF_FFFD, 32'h0000_0005, -1, 1'b1);
    checkOutput("mult_neg_lo_const", 64'(lo), 64'hFFFF_FFF1);
    runAndCheck("div_neg", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, -1, 1'b0);
    checkOutput("div_neg_lo_const", 64'(lo), 64'hFFFF_FFFD);
    runAndCheck("divu_zero", 2'b10, 32'h0000_0064, 32'h0, -1, 1'b0);
    runAndCheck("div_zero", 2'b11, 32'hFFFF_FFF0, 32'h0, -1, 1'b0);
    runAndCheck("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    checkOutput("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
    runAndCheck("mult_minint", 2'b01, 32'h8000_0000, 32'h8000_0000, -1, 1'b0);
    runAndCheck("multu67_glitch", 2'b00, 32'd6, 32'd7, 5, 1'b0);
    checkOutput("multu67_lo_const", 64'(lo), 64'h2A);

    applyStimulus(2'b10, 32'd9, 32'd2, -1, 11, 1'b0, bc, sd, ctl_mid, b_mid);
    checkOutput("flush_run_no_done", 64'(sd), 64'd0);
    checkOutput("flush_run_cycles", 64'(bc), 64'd11);
    checkOutput("flush_run_busy", 64'(busy), 64'd0);
    checkOutput("flush_run_lo_held", 64'(lo), 64'h2A);
    checkOutput("flush_run_hi_held", 64'(hi), 64'h0);
    done_count = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_count++;
    end
    checkOutput("flush_run_late_done", 64'(done_count), 64'd0);

    applyStimulus(2'b00, 32'h1234, 32'h10, -1, 34, 1'b0, bc, sd, ctl_mid, b_mid);
    checkOutput("flush_fix_no_done", 64'(sd), 64'd0);
    checkOutput("flush_fix_cycles", 64'(bc), 64'd34);
    checkOutput("flush_fix_lo_held", 64'(lo), 64'h2A);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 30);
      runAndCheck($sformatf("rand%0d", i), ro, ra, rb, -1, 1'b0);
    end

    runAndCheck("pre_rst", 2'b00, 32'd3, 32'd5, -1, 1'b0);
    start = 1'b1;
    op = 2'b00;
    a = 32'd7;
    b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_hi", 64'(hi), 64'd0);
    checkOutput("abort_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runAndCheck("post_rst", 2'b11, 32'hFFFF_FF9C, 32'd7, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
